// File: rtl/smix_pkg.sv
// smix_pkg: shared constants, state encoding and helpers for the SMIX sequencer.
//   SMIX_BLOCK_W      : width of one scrypt block (X) and one scratchpad entry
//   smix_state_t      : sequencer state encoding
//   integerify()      : Integerify(X) mod 2**n_log2
//   sp_index_to_addr(): scratchpad entry index to byte address (128-byte entries)
package smix_pkg;

  localparam int unsigned SMIX_BLOCK_W = 1024;
  localparam int unsigned SP_ENTRY_LOG2 = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_MIX1,
    S_RD,
    S_XOR,
    S_MIX2,
    S_DONE
  } smix_state_t;

  // Low n_log2 bits of the first 32-bit word of the last 64-byte sub-block.
  function automatic logic [31:0] integerify(input logic [SMIX_BLOCK_W-1:0] block,
                                             input int unsigned n_log2);
    return block[512 +: 32] & ((32'd1 << n_log2) - 32'd1);
  endfunction

  function automatic logic [31:0] sp_index_to_addr(input logic [31:0] index);
    return index << SP_ENTRY_LOG2;
  endfunction

endpackage

// File: rtl/smix_controller.sv
// smix_controller: scrypt SMIX loop sequencer.
//   Phase 1: N times { V[i] <= X ; X <= BlockMix(X) }
//   Phase 2: N times { X <= BlockMix(X ^ V[Integerify(X) mod N]) }
// Ports:
//   clk, n_rst              : clock, synchronous active-low reset
//   start, x_in             : launch request and initial block (sampled in IDLE)
//   busy, done, x_out       : status, one-cycle completion pulse, current X
//   mix_start, mix_in       : BlockMix request pulse and registered operand
//   mix_done, mix_out       : BlockMix completion pulse and result
//   sp_r_enable, sp_w_enable: scratchpad read / write strobes
//   sp_addr, sp_w_data      : scratchpad byte address and write data
//   sp_r_data               : scratchpad read data (one-cycle latency)
module smix_controller
  import smix_pkg::*;
#(
  parameter int unsigned N_LOG2  = 10,
  parameter int unsigned BLOCK_W = SMIX_BLOCK_W,
  parameter int unsigned ADDR_W  = 17
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic [BLOCK_W-1:0] x_in,
  output logic               busy,
  output logic               done,
  output logic [BLOCK_W-1:0] x_out,
  output logic               mix_start,
  output logic [BLOCK_W-1:0] mix_in,
  input  logic               mix_done,
  input  logic [BLOCK_W-1:0] mix_out,
  output logic               sp_r_enable,
  output logic               sp_w_enable,
  output logic [ADDR_W-1:0]  sp_addr,
  output logic [BLOCK_W-1:0] sp_w_data,
  input  logic [BLOCK_W-1:0] sp_r_data
);

  localparam int unsigned N_LAST = (1 << N_LOG2) - 1;

  smix_state_t        state;
  logic [BLOCK_W-1:0] x_r;
  logic [BLOCK_W-1:0] mix_in_r;
  logic [N_LOG2-1:0]  i_r;
  logic [N_LOG2-1:0]  i_inc;
  logic               i_last;
  logic [ADDR_W-1:0]  wr_next_addr;
  logic [ADDR_W-1:0]  rd_next_addr;

  assign i_inc  = i_r + N_LOG2'(1);
  assign i_last = (i_r == N_LOG2'(N_LAST));

  // Addresses for the access that follows a completed mix; derived from the
  // incoming result so the strobe and address can be registered together.
  assign wr_next_addr = ADDR_W'(sp_index_to_addr(32'(i_inc)));
  assign rd_next_addr = ADDR_W'(sp_index_to_addr(integerify(SMIX_BLOCK_W'(mix_out), N_LOG2)));

  assign x_out  = x_r;
  assign mix_in = mix_in_r;

  // Sequencer; every output is loaded on the transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state       <= S_IDLE;
      x_r         <= '0;
      mix_in_r    <= '0;
      i_r         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mix_start   <= 1'b0;
      sp_r_enable <= 1'b0;
      sp_w_enable <= 1'b0;
      sp_addr     <= '0;
      sp_w_data   <= '0;
    end else begin
      done        <= 1'b0;
      mix_start   <= 1'b0;
      sp_r_enable <= 1'b0;
      sp_w_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_WR;
            x_r         <= x_in;
            i_r         <= '0;
            busy        <= 1'b1;
            sp_w_enable <= 1'b1;
            sp_addr     <= '0;
            sp_w_data   <= x_in;
          end
        end
        S_WR: begin
          state     <= S_MIX1;
          mix_in_r  <= x_r;
          mix_start <= 1'b1;
        end
        S_MIX1: begin
          if (mix_done) begin
            x_r <= mix_out;
            if (i_last) begin
              state       <= S_RD;
              i_r         <= '0;
              sp_r_enable <= 1'b1;
              sp_addr     <= rd_next_addr;
            end else begin
              state       <= S_WR;
              i_r         <= i_inc;
              sp_w_enable <= 1'b1;
              sp_addr     <= wr_next_addr;
              sp_w_data   <= mix_out;
            end
          end
        end
        S_RD: begin
          state <= S_XOR;
        end
        S_XOR: begin
          state     <= S_MIX2;
          mix_in_r  <= x_r ^ sp_r_data;
          mix_start <= 1'b1;
        end
        S_MIX2: begin
          if (mix_done) begin
            x_r <= mix_out;
            if (i_last) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state       <= S_RD;
              i_r         <= i_inc;
              sp_r_enable <= 1'b1;
              sp_addr     <= rd_next_addr;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
